stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_stall_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// -----------------------------------------------------------------------------
// stall_ctrl
//
// Pipeline hazard and stall controller for a five-stage in-order core with an
// iterative multiply/divide unit.
//
// It does three jobs:
//    1. Detects load-use hazards between the instruction in D/X and the
//       instruction in F/D. On a hazard it holds PC and F/D and sends a
//       bubble into D/X.
//    2. Runs a small IDLE/BUSY/DONE sequencer for the multdiv unit. It issues
//       a one-cycle start pulse and freezes the whole front of the pipe while
//       the unit works. A timeout counter aborts a unit that never answers and
//       raises a sticky error flag.
//    3. Optionally counts stall cycles for performance analysis.
//
// Optional feature macro: STALL_PERF_CNT_EN
//    defined   : haz_cnt is a saturating count of cycles with stall_fd or
//                stall_all asserted.
//    undefined : haz_cnt is tied to zero and no counter register is built.
//
// Parameters
//    W          : instruction width (fields live in the low 32 bits)
//    RW         : register-address width
//    LOAD_OP    : opcode that identifies a load
//    MD_TIMEOUT : BUSY cycles allowed before the multdiv operation is aborted
//                 (legal range 2..1024)
//    CNT_W      : width of the stall-cycle performance counter
//
// Ports
//    clock      : in  : single clock, all state changes on its rising edge
//    reset      : in  : synchronous, active-low reset
//    fdIR       : in  : instruction held in the F/D latch
//    dxIR       : in  : instruction held in the D/X latch
//    flush      : in  : taken branch/jump resolved in X this cycle
//    md_ready   : in  : multdiv result valid
//    stall_fd   : out : hold PC and F/D (load-use hazard)
//    bubble_dx  : out : load a nop into D/X (same condition as stall_fd)
//    stall_all  : out : freeze PC, F/D, D/X and X/M (multdiv in flight)
//    md_start   : out : one-cycle start pulse to the multdiv unit
//    md_err     : out : sticky multdiv timeout flag, cleared only by reset
//    haz_cnt    : out : stall-cycle count (zero unless STALL_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module stall_ctrl #(
   parameter int         W          = 32,
   parameter int         RW         = 5,
   parameter logic [4:0] LOAD_OP    = 5'b01000,
   parameter int         MD_TIMEOUT = 64,
   parameter int         CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [W-1:0]     fdIR,
   input  logic [W-1:0]     dxIR,
   input  logic             flush,
   input  logic             md_ready,
   output logic             stall_fd,
   output logic             bubble_dx,
   output logic             stall_all,
   output logic             md_start,
   output logic             md_err,
   output logic [CNT_W-1:0] haz_cnt
);

   // Timeout counter only has to reach MD_TIMEOUT-1.
   localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(MD_TIMEOUT - 1);

   // Opcodes and ALU ops the decoder cares about.
   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_SW    = 5'b00111;
   localparam logic [4:0] OP_BNE   = 5'b00010;
   localparam logic [4:0] OP_BLT   = 5'b00110;
   localparam logic [4:0] OP_JR    = 5'b00100;
   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t        state;
   logic [TW-1:0] tmo_cnt;

   // ---------------------------------------------------------------------------
   // Instruction field extraction
   // ---------------------------------------------------------------------------
   logic [4:0]    fd_op;
   logic [RW-1:0] fd_rd;
   logic [RW-1:0] fd_rs;
   logic [RW-1:0] fd_rt;
   logic [4:0]    dx_op;
   logic [RW-1:0] dx_rd;
   logic [4:0]    dx_aluop;

   assign fd_op    = fdIR[31:27];
   assign fd_rd    = fdIR[22 +: RW];
   assign fd_rs    = fdIR[17 +: RW];
   assign fd_rt    = fdIR[12 +: RW];
   assign dx_op    = dxIR[31:27];
   assign dx_rd    = dxIR[22 +: RW];
   assign dx_aluop = dxIR[6:2];

   // Only a subset of the instruction bits is decoded here. Folding the
   // whole words into one sink keeps the rest of each word visibly consumed.
   logic unused_ir_bits;
   assign unused_ir_bits = ^{fdIR, dxIR};

   // ---------------------------------------------------------------------------
   // Load-use hazard detection
   // ---------------------------------------------------------------------------
   // rs is read by every format. rt is read only by R-type. Stores, branches
   // and jr read the register in the rd slot as a source. Register 0 is
   // hard-wired, so it can never carry a dependency.
   logic rt_used;
   logic rd_used;
   logic hit_rs;
   logic hit_rt;
   logic hit_rd;
   logic load_use;

   assign rt_used = (fd_op == OP_RTYPE);
   assign rd_used = (fd_op == OP_SW) || (fd_op == OP_BNE) ||
                    (fd_op == OP_BLT) || (fd_op == OP_JR);

   assign hit_rs = (fd_rs != '0) && (fd_rs == dx_rd);
   assign hit_rt = rt_used && (fd_rt != '0) && (fd_rt == dx_rd);
   assign hit_rd = rd_used && (fd_rd != '0) && (fd_rd == dx_rd);

   assign load_use = (dx_op == LOAD_OP) && (dx_rd != '0) &&
                     (hit_rs || hit_rt || hit_rd);

   // ---------------------------------------------------------------------------
   // Multiply/divide detection
   // ---------------------------------------------------------------------------
   logic md_inst;

   assign md_inst = (dx_op == OP_RTYPE) &&
                    ((dx_aluop == ALU_MUL) || (dx_aluop == ALU_DIV));

   // ---------------------------------------------------------------------------
   // Stall outputs
   // ---------------------------------------------------------------------------
   // stall_all is raised in the very cycle the multdiv instruction is seen in
   // IDLE, so the pipe freezes with zero latency, and stays up through BUSY.
   // DONE releases the pipe so the result can move on. A full freeze and a
   // flush both override the load-use bubble: a frozen pipe has nothing to
   // bubble, and a flushed F/D instruction is being discarded anyway.
   assign stall_all = ((state == IDLE) && md_inst) || (state == BUSY);
   assign stall_fd  = load_use && !stall_all && !flush;
   assign bubble_dx = stall_fd;

   // The start pulse has to line up with the first frozen cycle, so it is
   // decoded from IDLE and md_inst rather than registered. Gating with reset
   // keeps the unit quiet while the controller is held in reset. A flush in
   // that cycle does not cancel it because the multdiv is already in X.
   assign md_start = reset && (state == IDLE) && md_inst;

   // ---------------------------------------------------------------------------
   // Multdiv sequencer
   // ---------------------------------------------------------------------------
   // IDLE -> BUSY when a multdiv instruction sits in D/X.
   // BUSY -> DONE on md_ready, or when the timeout counter hits its last
   //         value. On a timeout the sticky error flag is also set. md_ready
   //         wins if both happen in the same cycle.
   // DONE -> IDLE unconditionally. This gives back-to-back operations a
   //         single-cycle gap.
   // The error flag never blocks later operations. It only records that an
   // abort happened.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= IDLE;
         tmo_cnt <= '0;
         md_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (md_inst) begin
                  state   <= BUSY;
                  tmo_cnt <= '0;
               end
            end
            BUSY: begin
               if (md_ready) begin
                  state <= DONE;
               end else if (tmo_cnt == TMO_LAST) begin
                  state  <= DONE;
                  md_err <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Stall-cycle performance counter
   // ---------------------------------------------------------------------------
`ifdef STALL_PERF_CNT_EN
   logic [CNT_W-1:0] perf_cnt;

   // Counts every cycle the front end is held. It sticks at all-ones instead
   // of wrapping, so an overflow reads as "at least this many".
   always_ff @(posedge clock) begin
      if (!reset) begin
         perf_cnt <= '0;
      end else if ((stall_fd || stall_all) && (perf_cnt != '1)) begin
         perf_cnt <= perf_cnt + 1'b1;
      end
   end

   assign haz_cnt = perf_cnt;
`else
   assign haz_cnt = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_ctrl
//
// Testbench for stall_ctrl.
//
// It drives directed scenarios followed by randomized traffic. A behavioural
// model checks every cycle. The model keeps the multdiv operation as "in
// flight for N cycles" plus a one-cycle release marker, and it decodes
// register dependencies as a list of source registers.
// -----------------------------------------------------------------------------
module tb_stall_ctrl;

   localparam int         T      = 6;
   localparam int         CW     = 4;
   localparam logic [4:0] LOADOP = 5'b01000;
   localparam int         PMAX   = (1 << CW) - 1;

   logic          clock = 1'b0;
   logic          reset;
   logic [31:0]   fdIR;
   logic [31:0]   dxIR;
   logic          flush;
   logic          md_ready;
   logic          stall_fd;
   logic          bubble_dx;
   logic          stall_all;
   logic          md_start;
   logic          md_err;
   logic [CW-1:0] haz_cnt;

   int checks = 0;
   int errors = 0;

   // Model state
   bit opInFlight;
   int cyclesInFlight;
   bit releaseCycle;
   bit errModel;
   int perfModel;
   bit lastStall;

   always #5 clock = ~clock;

   stall_ctrl #(
      .W(32), .RW(5), .LOAD_OP(LOADOP), .MD_TIMEOUT(T), .CNT_W(CW)
   ) dut (
      .clock(clock), .reset(reset), .fdIR(fdIR), .dxIR(dxIR), .flush(flush),
      .md_ready(md_ready), .stall_fd(stall_fd), .bubble_dx(bubble_dx),
      .stall_all(stall_all), .md_start(md_start), .md_err(md_err),
      .haz_cnt(haz_cnt)
   );

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] alu);
      return {op, rd, rs, rt, 5'b00000, alu, 2'b00};
   endfunction

   function automatic bit readsReg(input logic [31:0] ir, input logic [4:0] r);
      logic [4:0] srcs[$];
      logic [4:0] op;
      op = ir[31:27];
      srcs.push_back(ir[21:17]);
      if (op == 5'd0) srcs.push_back(ir[16:12]);
      if (op == 5'd7 || op == 5'd2 || op == 5'd6 || op == 5'd4) srcs.push_back(ir[26:22]);
      if (r == 5'd0) return 1'b0;
      foreach (srcs[i]) if (srcs[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit isMulDiv(input logic [31:0] ir);
      return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6 || ir[6:2] == 5'd7);
   endfunction

   task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      bit idle;
      bit mdi;
      bit haz;
      bit expAll;
      bit expStart;
      bit expFd;
      int expCnt;
      idle     = !opInFlight && !releaseCycle;
      mdi      = isMulDiv(dxIR);
      haz      = (dxIR[31:27] == LOADOP) && readsReg(fdIR, dxIR[26:22]);
      expAll   = (idle && mdi) || opInFlight;
      expStart = idle && mdi && reset;
      expFd    = haz && !expAll && !flush;
`ifdef STALL_PERF_CNT_EN
      expCnt   = perfModel;
`else
      expCnt   = 0;
`endif
      checkVal("stall_fd", 16'(stall_fd), 16'(expFd));
      checkVal("bubble_dx", 16'(bubble_dx), 16'(expFd));
      checkVal("stall_all", 16'(stall_all), 16'(expAll));
      checkVal("md_start", 16'(md_start), 16'(expStart));
      checkVal("md_err", 16'(md_err), 16'(errModel));
      checkVal("haz_cnt", 16'(haz_cnt), 16'(expCnt));
      lastStall = expFd || expAll;
   endtask

   task automatic updateModel(input bit mdi);
      if (!reset) begin
         opInFlight     = 1'b0;
         cyclesInFlight = 0;
         releaseCycle   = 1'b0;
         errModel       = 1'b0;
         perfModel      = 0;
      end else begin
         if (lastStall && perfModel < PMAX) perfModel++;
         if (opInFlight) begin
            cyclesInFlight++;
            if (md_ready || cyclesInFlight == T) begin
               if (!md_ready) errModel = 1'b1;
               opInFlight   = 1'b0;
               releaseCycle = 1'b1;
            end
         end else if (releaseCycle) begin
            releaseCycle = 1'b0;
         end else if (mdi) begin
            opInFlight     = 1'b1;
            cyclesInFlight = 0;
         end
      end
   endtask

   // Drive one cycle of inputs at the falling edge, check just after, then
   // advance the model across the rising edge.
   task automatic applyStimulus(input logic [31:0] fd, input logic [31:0] dx,
                                input logic fl, input logic rdy, input logic rst);
      bit mdi;
      fdIR     = fd;
      dxIR     = dx;
      flush    = fl;
      md_ready = rdy;
      reset    = rst;
      #1;
      checkOutput();
      mdi = isMulDiv(dx);
      @(posedge clock);
      updateModel(mdi);
      @(negedge clock);
   endtask

   initial begin
      logic [31:0] nop;
      logic [31:0] lw3;
      logic [31:0] mul;
      logic [31:0] dv;
      logic [4:0]  fdOps[7];
      nop = 32'd0;
      lw3 = mk(LOADOP, 5'd3, 5'd1, 5'd0, 5'd0);
      mul = mk(5'd0, 5'd6, 5'd1, 5'd2, 5'd6);
      dv  = mk(5'd0, 5'd7, 5'd1, 5'd2, 5'd7);
      fdOps = '{5'd0, 5'd7, 5'd2, 5'd6, 5'd4, 5'd5, 5'd8};

      // Unchecked reset to bring the DUT out of an unknown power-up state.
      fdIR = nop; dxIR = nop; flush = 1'b0; md_ready = 1'b0; reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      opInFlight = 1'b0; cyclesInFlight = 0; releaseCycle = 1'b0;
      errModel = 1'b0; perfModel = 0; lastStall = 1'b0;

      $display("[TB] reset state");
      applyStimulus(nop, nop, 1'b0, 1'b0, 1'b0);
      applyStimulus(nop, nop, 1'b0, 1'b0, 1'b1);

      $display("[TB] load-use hazards");
      applyStimulus(mk(5'd0, 5'd5, 5'd3, 5'd4, 5'd0), lw3, 1'b0, 1'b0, 1'b1);
      applyStimulus(mk(5'd0, 5'd5, 5'd3, 5'd4, 5'd0), nop, 1'b0, 1'b0, 1'b1);
      applyStimulus(mk(5'd0, 5'd5, 5'd0, 5'd0, 5'd0), mk(LOADOP, 5'd0, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 1'b1);
      applyStimulus(mk(5'd7, 5'd3, 5'd2, 5'd0, 5'd0), lw3, 1'b0, 1'b0, 1'b1);
      applyStimulus(mk(5'd5, 5'd5, 5'd1, 5'd3, 5'd0), lw3, 1'b0, 1'b0, 1'b1);
      applyStimulus(mk(5'd2, 5'd3, 5'd1, 5'd0, 5'd0), lw3, 1'b0, 1'b0, 1'b1);
      applyStimulus(mk(5'd0, 5'd5, 5'd1, 5'd3, 5'd0), lw3, 1'b1, 1'b0, 1'b1);

      $display("[TB] multdiv with md_ready after five cycles");
      applyStimulus(nop, nop, 1'b0, 1'b1, 1'b1);
      applyStimulus(nop, mul, 1'b1, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) applyStimulus(nop, mul, (i == 2), 1'b0, 1'b1);
      applyStimulus(nop, mul, 1'b0, 1'b1, 1'b1);
      applyStimulus(nop, mul, 1'b0, 1'b0, 1'b1);
      applyStimulus(nop, dv, 1'b0, 1'b0, 1'b1);
      applyStimulus(nop, dv, 1'b0, 1'b1, 1'b1);
      applyStimulus(nop, nop, 1'b0, 1'b0, 1'b1);

      $display("[TB] multdiv timeout");
      for (int i = 0; i < T + 3; i++) applyStimulus(nop, dv, 1'b0, 1'b0, 1'b1);
      applyStimulus(nop, nop, 1'b0, 1'b0, 1'b1);
      applyStimulus(nop, nop, 1'b0, 1'b0, 1'b1);

      $display("[TB] reset in the middle of an operation");
      applyStimulus(nop, mul, 1'b0, 1'b0, 1'b1);
      applyStimulus(nop, mul, 1'b0, 1'b0, 1'b1);
      applyStimulus(nop, mul, 1'b0, 1'b0, 1'b0);
      applyStimulus(nop, nop, 1'b0, 1'b0, 1'b1);

      $display("[TB] counter saturation over twenty stall cycles");
      for (int i = 0; i < 20; i++)
         applyStimulus(mk(5'd0, 5'd5, 5'd3, 5'd4, 5'd0), lw3, 1'b0, 1'b0, 1'b1);
      applyStimulus(nop, nop, 1'b0, 1'b0, 1'b1);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         logic [31:0] fd;
         logic [31:0] dx;
         int          kind;
         kind = int'($urandom_range(0, 4));
         case (kind)
            0: dx = mk(LOADOP, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'd0, 5'd0);
            1: dx = mk(5'd0, 5'($urandom_range(0, 3)), 5'd1, 5'd2, 5'($urandom_range(6, 7)));
            2: dx = mk(5'd0, 5'($urandom_range(0, 3)), 5'd1, 5'd2, 5'($urandom_range(0, 31)));
            3: dx = $urandom;
            default: dx = mk(5'($urandom_range(1, 31)), 5'($urandom_range(0, 3)), 5'd1, 5'd2, 5'd0);
         endcase
         fd = mk(fdOps[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
         applyStimulus(fd, dx, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 39) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
